qspi_xip_reader: RTL and testbench
==================================

Name: qspi_xip_reader

Overview:
- Quad-SPI execute-in-place read engine for the core's instruction/data path. It turns a 32-bit word read request into a Winbond W25Q128JV "Fast Read Quad I/O" (0xEB) transaction and returns the assembled little-endian word.
- Sits between the core's memory port and the off-chip flash pins (qspi_io_io, qspi_ck_o, qspi_cs_o).
- The flash has QE=1 by factory default, so no configuration writes are issued.

Parameters:
- CMD, 8'hEB, read opcode, sent single-line, MSB first.
- MODE_BYTE, 8'h00, continuous-read mode byte; M[5:4] != 2'b10, so continuous mode is never entered.
- DUMMY_SCK, 4, dummy SCK cycles after the mode byte.
- STARTUP_CYCLES, 4000, clk cycles after reset before the first request is accepted (flash power-up, ~25 us at 160 MHz).

Ports:
- clk_i  in  1  system clock, rising-edge.
- rst_i  in  1  synchronous, active-high reset.
- req_i  in  1  read request; accepted on a rising clk edge where req_i=1 and ready_o=1.
- addr_i  in  24  byte address; bits [1:0] are ignored and forced to 0.
- ready_o  out  1  engine idle and able to accept a request.
- rvalid_o  out  1  one-cycle pulse; rdata_o is valid.
- rdata_o  out  32  read word; byte at addr → [7:0], addr+3 → [31:24].
- qspi_io_io  inout  4  flash IO[3:0] (DIO, DO, WPn, HOLDn), tri-stated per bit.
- qspi_ck_o  out  1  SPI clock, mode 0 (idles low).
- qspi_cs_o  out  1  chip select, active low.

Behaviour:
- Reset values:
  - cs=1, ck=0, ready_o=0, rvalid_o=0, rdata_o=0.
  - IO0 driven 0; IO1 hi-Z; IO2 and IO3 driven 1.
- After reset deasserts, a counter holds ready_o low for STARTUP_CYCLES clk cycles, then ready_o goes 1.
- SCK = clk/2. Each SCK cycle is two clk cycles:
  - LOW half (ck=0): the engine updates its driven IO.
  - HIGH half (ck=1): the engine samples IO at the clk edge that ends the HIGH half.
- Transaction of 28 SCK cycles (56 clk, cs=0 throughout), phases in order:
  - CMD, 8 SCK: IO0 carries the CMD bits MSB first; IO1 hi-Z; IO2 and IO3 driven 1.
  - ADDR, 6 SCK: IO[3:0] carry addr nibbles, most-significant nibble first.
  - MODE, 2 SCK: IO[3:0] carry MODE_BYTE, high nibble first.
  - DUMMY, DUMMY_SCK: all IO hi-Z.
  - DATA, 8 SCK: all IO hi-Z; IO[3:0] is sampled each SCK. Nibble pairs form bytes (high nibble first), and bytes fill rdata bits [7:0], [15:8], [23:16], [31:24] in that order.
- Timing (request accepted at edge E0, i.e. the cycle where req_i & ready_o):
  - ready_o drops on the next cycle.
  - Cycles 1..56: cs=0.
  - Cycle 57: cs=1, ck=0, rvalid_o=1, rdata_o updated. rdata_o holds until the next rvalid_o.
  - Cycle 58: cs=1, ready_o=1.
  - Minimum cs-high time between transactions is 2 clk; back-to-back start-to-start spacing is 58 clk.
- IO drive after DATA: IO2/IO3 return to driven-1 and IO0 to driven-0 only after cs rises.
- No bus contention: the engine never drives IO0..IO3 during DUMMY or DATA.
- req_i while ready_o=0 is ignored (no queueing).
- rst_i mid-transaction:
  - Next cycle cs=1, ck=0, rvalid_o=0, rdata_o=0.
  - No pulse is issued for the aborted read.
  - The STARTUP_CYCLES wait restarts.
- States: STARTUP → IDLE → CMD → ADDR → MODE → DUMMY → DATA → DONE (rvalid) → IDLE.

Test Plan:
- Reset then idle: rst_i high 2 cycles, then low → cs=1 and ck=0 throughout; ready_o=0 for 4000 cycles, then 1.
- Read addr 0x000000 with flash bytes 13 05 00 00 → rvalid_o exactly 57 cycles after accept; rdata_o=0x00000513.
- Read addr 0x001236 → the ADDR phase transmits 0x001234; CMD bits on IO0 are 1110_1011; MODE nibbles are 0,0.
- Back-to-back reads at 0x000004 then 0x000008 → cs high for exactly 2 cycles between them; the two rdata values equal the flash words at 4 and 8.
- req_i held high while busy → exactly one transaction per ready window; no extra rvalid pulses.
- rst_i asserted at cycle 30 of a read → cs=1 on the next cycle; no rvalid; a fresh read after startup returns correct data.

Source files
------------

// File: rtl/qspi_xip_reader.sv
// Execute-in-place word reader for a W25Q128JV-class flash using Fast Read Quad I/O.
// One request returns one little-endian 32-bit word; SCK runs at clk/2 in SPI mode 0.
module qspi_xip_reader #(
  parameter logic [7:0] CMD            = 8'hEB,
  parameter logic [7:0] MODE_BYTE      = 8'h00,
  parameter int         DUMMY_SCK      = 4,
  parameter int         STARTUP_CYCLES = 4000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic [23:0] addr_i,
  output logic        ready_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  inout  wire  [3:0]  qspi_io_io,
  output logic        qspi_ck_o,
  output logic        qspi_cs_o
);

  localparam int                   STARTUP_W      = $clog2(STARTUP_CYCLES + 1);
  localparam logic [STARTUP_W-1:0] STARTUP_LAST_C = STARTUP_W'(STARTUP_CYCLES - 1);
  // Idle drive keeps WPn/HOLDn high and DI low while DO floats.
  localparam logic [3:0]           IDLE_OE_C      = 4'b1101;
  localparam logic [3:0]           IDLE_OUT_C     = 4'b1100;

  typedef enum logic [2:0] {
    ST_STARTUP,
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_MODE,
    ST_DUMMY,
    ST_DATA,
    ST_DONE
  } state_t;

  state_t               state_r;
  logic                 half_r;
  logic [2:0]           cnt_r;
  logic [STARTUP_W-1:0] startup_cnt_r;
  logic [23:0]          addr_r;
  logic [27:0]          data_sr_r;
  logic [3:0]           io_oe_r;
  logic [3:0]           io_out_r;
  logic                 ready_r;
  logic                 rvalid_r;
  logic [31:0]          rdata_r;
  logic                 ck_r;
  logic                 cs_r;

  // Pad drive {oe, out} for a given SCK of a phase.
  function automatic logic [7:0] io_drive(input state_t st, input logic [2:0] cnt,
                                          input logic [23:0] addr);
    logic [7:0]  cmd_sh;
    logic [23:0] addr_sh;
    logic [7:0]  drv;
    cmd_sh  = CMD << cnt;
    addr_sh = addr << {cnt, 2'b00};
    case (st)
      ST_CMD:   drv = {4'b1101, 3'b110, cmd_sh[7]};
      ST_ADDR:  drv = {4'b1111, addr_sh[23:20]};
      ST_MODE:  drv = {4'b1111, (cnt == 3'd0) ? MODE_BYTE[7:4] : MODE_BYTE[3:0]};
      ST_DUMMY: drv = {4'b0000, 4'b0000};
      ST_DATA:  drv = {4'b0000, 4'b0000};
      default:  drv = {IDLE_OE_C, IDLE_OUT_C};
    endcase
    return drv;
  endfunction

  function automatic logic [2:0] phase_last(input state_t st);
    logic [2:0] last;
    case (st)
      ST_CMD:   last = 3'd7;
      ST_ADDR:  last = 3'd5;
      ST_MODE:  last = 3'd1;
      ST_DUMMY: last = 3'(DUMMY_SCK - 1);
      ST_DATA:  last = 3'd7;
      default:  last = 3'd0;
    endcase
    return last;
  endfunction

  function automatic state_t next_phase(input state_t st);
    state_t nx;
    case (st)
      ST_CMD:   nx = ST_ADDR;
      ST_ADDR:  nx = ST_MODE;
      ST_MODE:  nx = ST_DUMMY;
      ST_DUMMY: nx = ST_DATA;
      ST_DATA:  nx = ST_DONE;
      default:  nx = ST_IDLE;
    endcase
    return nx;
  endfunction

  // Nibbles arrive high-first per byte and bytes arrive lowest address first.
  function automatic logic [31:0] nibbles_to_word(input logic [31:0] sr);
    return {sr[7:0], sr[15:8], sr[23:16], sr[31:24]};
  endfunction

  // Sequencer: power-up hold-off, SCK generation, pad drive, data capture.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r       <= ST_STARTUP;
      half_r        <= 1'b0;
      cnt_r         <= 3'd0;
      startup_cnt_r <= '0;
      addr_r        <= 24'h000000;
      data_sr_r     <= 28'h0000000;
      io_oe_r       <= IDLE_OE_C;
      io_out_r      <= IDLE_OUT_C;
      ready_r       <= 1'b0;
      rvalid_r      <= 1'b0;
      rdata_r       <= 32'h00000000;
      ck_r          <= 1'b0;
      cs_r          <= 1'b1;
    end else begin
      case (state_r)
        ST_STARTUP: begin
          if (startup_cnt_r == STARTUP_LAST_C) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b1;
          end else begin
            startup_cnt_r <= startup_cnt_r + 1'b1;
          end
        end
        ST_IDLE: begin
          if (req_i && ready_r) begin
            state_r               <= ST_CMD;
            cnt_r                 <= 3'd0;
            half_r                <= 1'b0;
            addr_r                <= addr_i & 24'hFFFFFC;
            ready_r               <= 1'b0;
            cs_r                  <= 1'b0;
            ck_r                  <= 1'b0;
            {io_oe_r, io_out_r}   <= io_drive(ST_CMD, 3'd0, addr_r);
          end
        end
        ST_CMD, ST_ADDR, ST_MODE, ST_DUMMY, ST_DATA: begin
          if (!half_r) begin
            half_r <= 1'b1;
            ck_r   <= 1'b1;
          end else begin
            // End of the high half: sample, then set up the next SCK's drive.
            half_r <= 1'b0;
            ck_r   <= 1'b0;
            if (state_r == ST_DATA) begin
              data_sr_r <= {data_sr_r[23:0], qspi_io_io};
            end
            if (cnt_r != phase_last(state_r)) begin
              cnt_r               <= cnt_r + 3'd1;
              {io_oe_r, io_out_r} <= io_drive(state_r, cnt_r + 3'd1, addr_r);
            end else begin
              cnt_r               <= 3'd0;
              state_r             <= next_phase(state_r);
              {io_oe_r, io_out_r} <= io_drive(next_phase(state_r), 3'd0, addr_r);
              if (state_r == ST_DATA) begin
                cs_r     <= 1'b1;
                rvalid_r <= 1'b1;
                rdata_r  <= nibbles_to_word({data_sr_r, qspi_io_io});
              end
            end
          end
        end
        ST_DONE: begin
          rvalid_r <= 1'b0;
          ready_r  <= 1'b1;
          state_r  <= ST_IDLE;
        end
        default: begin
          state_r             <= ST_STARTUP;
          startup_cnt_r       <= '0;
          ready_r             <= 1'b0;
          rvalid_r            <= 1'b0;
          cs_r                <= 1'b1;
          ck_r                <= 1'b0;
          {io_oe_r, io_out_r} <= {IDLE_OE_C, IDLE_OUT_C};
        end
      endcase
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_io
    assign qspi_io_io[i] = io_oe_r[i] ? io_out_r[i] : 1'bz;
  end

  assign ready_o   = ready_r;
  assign rvalid_o  = rvalid_r;
  assign rdata_o   = rdata_r;
  assign qspi_ck_o = ck_r;
  assign qspi_cs_o = cs_r;

endmodule

// File: tb/tb_qspi_xip_reader.sv
// Bench for qspi_xip_reader: behavioural quad-I/O flash plus directed and random reads.
module tb_qspi_xip_reader;

  localparam int DATA_FIRST_SCK = 8 + 6 + 2 + 4;
  localparam int DATA_END_SCK   = DATA_FIRST_SCK + 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [23:0] addr = 24'h000000;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;
  logic        ck;
  logic        cs;
  wire  [3:0]  qspi_io;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  qspi_xip_reader dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_i      (req),
    .addr_i     (addr),
    .ready_o    (ready),
    .rvalid_o   (rvalid),
    .rdata_o    (rdata),
    .qspi_io_io (qspi_io),
    .qspi_ck_o  (ck),
    .qspi_cs_o  (cs)
  );

  // Flash model: 4 KiB image aliased across the address space.
  logic [7:0]  mem [0:4095];
  logic        fl_oe = 1'b0;
  logic [3:0]  fl_dq = 4'h0;
  int          sck_n = 0;
  int          fl_idx;
  logic [7:0]  fl_b;
  logic [7:0]  cap_cmd = 8'h00;
  logic [23:0] cap_addr = 24'h000000;
  logic [7:0]  cap_mode = 8'hFF;

  assign qspi_io = fl_oe ? fl_dq : 4'bzzzz;

  always @(negedge cs) sck_n = 0;
  always @(posedge cs) fl_oe = 1'b0;

  always @(posedge ck) begin
    if (!cs) begin
      if (sck_n < 8)       cap_cmd  = {cap_cmd[6:0], qspi_io[0]};
      else if (sck_n < 14) cap_addr = {cap_addr[19:0], qspi_io};
      else if (sck_n < 16) cap_mode = {cap_mode[3:0], qspi_io};
      sck_n++;
    end
  end

  always @(negedge ck) begin
    if (!cs && sck_n >= DATA_FIRST_SCK && sck_n < DATA_END_SCK) begin
      fl_idx = sck_n - DATA_FIRST_SCK;
      fl_b   = mem[int'(cap_addr[11:0]) + fl_idx / 2];
      #2;
      fl_dq  = (fl_idx % 2 == 1) ? fl_b[3:0] : fl_b[7:4];
      fl_oe  = 1'b1;
    end else begin
      fl_oe = 1'b0;
    end
  end

  // Length of the most recent completed cs-high run, in clk cycles.
  int hi_run = 0;
  int last_gap = 0;
  always @(negedge clk) begin
    if (cs) hi_run++;
    else begin
      if (hi_run != 0) last_gap = hi_run;
      hi_run = 0;
    end
  end

  function automatic logic [31:0] ref_word(input logic [23:0] a);
    int base;
    base = int'(a[11:2]) * 4;
    return {mem[base + 3], mem[base + 2], mem[base + 1], mem[base]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 10000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "/ready_wait"}, 32'(ready), 32'd1);
  endtask

  task automatic do_read(input logic [23:0] a, input string tag);
    int   rv_cnt;
    int   rv_at;
    int   cs_bad;
    logic [31:0] got;
    wait_ready(tag);
    req  = 1'b1;
    addr = a;
    @(posedge clk);
    rv_cnt = 0; rv_at = 0; cs_bad = 0; got = 32'h0;
    for (int n = 1; n <= 58; n++) begin
      @(negedge clk);
      if (n == 1) begin
        req = 1'b0;
        check({tag, "/ready_drop"}, 32'(ready), 32'd0);
      end
      if (n <= 56 && cs !== 1'b0) cs_bad++;
      if (rvalid === 1'b1) begin
        rv_cnt++;
        rv_at = n;
        got   = rdata;
      end
      if (n == 57) begin
        check({tag, "/cs_end"}, 32'(cs), 32'd1);
        check({tag, "/ck_end"}, 32'(ck), 32'd0);
      end
      if (n == 58) begin
        check({tag, "/ready_back"}, 32'(ready), 32'd1);
        check({tag, "/rdata_hold"}, rdata, ref_word(a));
      end
    end
    check({tag, "/cs_low_56"}, 32'(cs_bad), 32'd0);
    check({tag, "/pulses"}, 32'(rv_cnt), 32'd1);
    check({tag, "/latency"}, 32'(rv_at), 32'd57);
    check({tag, "/rdata"}, got, ref_word(a));
    check({tag, "/cmd"}, 32'(cap_cmd), 32'h000000EB);
    check({tag, "/addr"}, 32'(cap_addr), 32'({a[23:2], 2'b00}));
    check({tag, "/mode"}, 32'(cap_mode), 32'h00000000);
  endtask

  initial begin
    int lows;
    int bad;
    int pulses;
    int rdy_hi;
    int rv_seen;
    logic [23:0] ha;

    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h00; mem[3] = 8'h00;

    // Reset for two edges, then the power-up hold-off.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst/cs", 32'(cs), 32'd1);
    check("rst/ck", 32'(ck), 32'd0);
    check("rst/ready", 32'(ready), 32'd0);
    check("rst/rvalid", 32'(rvalid), 32'd0);
    check("rst/rdata", rdata, 32'h0);
    rst  = 1'b0;
    lows = 1;
    bad  = 0;
    for (int n = 0; n < 5000 && ready !== 1'b1; n++) begin
      @(negedge clk);
      if (cs !== 1'b1 || ck !== 1'b0) bad++;
      if (ready !== 1'b1) lows++;
    end
    check("startup/low_cycles", 32'(lows), 32'd4000);
    check("startup/ready", 32'(ready), 32'd1);
    check("startup/pins_idle", 32'(bad), 32'd0);

    do_read(24'h000000, "rd0");
    check("rd0/word", rdata, 32'h00000513);
    do_read(24'h001236, "rd1236");

    // Back-to-back: second request issued in the first cycle ready returns.
    do_read(24'h000004, "b2b4");
    do_read(24'h000008, "b2b8");
    check("b2b/cs_gap", 32'(last_gap), 32'd2);

    for (int i = 0; i < 4; i++) begin
      do_read(24'($urandom), $sformatf("rnd%0d", i));
    end

    // req held high: one transaction per ready window.
    ha = 24'($urandom);
    wait_ready("hold");
    req = 1'b1; addr = ha;
    @(posedge clk);
    pulses = 0; rdy_hi = 0; bad = 0;
    for (int n = 1; n <= 174; n++) begin
      @(negedge clk);
      if (rvalid === 1'b1) begin
        pulses++;
        if (rdata !== ref_word(ha)) bad++;
      end
      if (n <= 173 && ready === 1'b1) rdy_hi++;
    end
    req = 1'b0;
    check("hold/pulses", 32'(pulses), 32'd3);
    check("hold/ready_windows", 32'(rdy_hi), 32'd2);
    check("hold/data_bad", 32'(bad), 32'd0);

    // Abort a read with reset in cycle 30.
    wait_ready("abort");
    req = 1'b1; addr = 24'h000100;
    @(posedge clk);
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 1) req = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort/cs", 32'(cs), 32'd1);
    check("abort/ck", 32'(ck), 32'd0);
    check("abort/rvalid", 32'(rvalid), 32'd0);
    check("abort/rdata", rdata, 32'h0);
    check("abort/ready", 32'(ready), 32'd0);
    rst = 1'b0;
    rv_seen = 0;
    lows = 1;
    for (int n = 0; n < 5000 && ready !== 1'b1; n++) begin
      @(negedge clk);
      if (rvalid === 1'b1) rv_seen++;
      if (ready !== 1'b1) lows++;
    end
    check("abort/no_pulse", 32'(rv_seen), 32'd0);
    check("abort/restart_wait", 32'(lows), 32'd4000);
    do_read(24'($urandom), "post_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
